// File: rtl/system_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_bus_pkg
// Description : Shared bus types and constants for the system bus RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package system_bus_pkg;

    localparam int BUS_DATA_BYTES = 4;
    localparam int BUS_ADDR_BITS  = 30;

    typedef logic [BUS_ADDR_BITS-1:0]    word_addr_t;
    typedef logic [8*BUS_DATA_BYTES-1:0] word_t;
    typedef logic [BUS_DATA_BYTES-1:0]   byte_en_t;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_t;

endpackage
`default_nettype wire

// File: rtl/system_bus_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : system_bus_ram_array
// Description : 1R1W word array, per-byte write enables, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module system_bus_ram_array
    import system_bus_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  byte_en_t             i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  word_t                i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output word_t                o_rdata
);

    localparam int c_DEPTH = 2**ADDR_BITS;

    // One narrow array per lane keeps byte writes mappable onto plain RAMs.
    generate
        for (genvar i = 0; i < BUS_DATA_BYTES; i++) begin : g_lane
            logic [7:0] r_mem [c_DEPTH];
            logic [7:0] r_q;

            always_ff @(posedge clk) begin
                if (i_we[i]) begin
                    r_mem[i_waddr] <= i_wdata[8*i +: 8];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (i_re) begin
                    r_q <= r_mem[i_raddr];
                end
            end

            assign o_rdata[8*i +: 8] = r_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/system_bus_ram.sv
`default_nettype none
// ============================================================================
// Module      : system_bus_ram
// Description : System bus responder RAM with optional post-reset zero fill.
// Revision    : 1.0 - initial release
// ============================================================================
module system_bus_ram
    import system_bus_pkg::*;
#(
    parameter int ADDR_BITS      = 12,
    parameter int BASE_ADDR      = 0,
    parameter int READ_LATENCY   = 2,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    output logic       bus_ready,
    input  word_addr_t bus_addr,
    input  word_t      bus_write_data,
    input  byte_en_t   bus_byte_enable,
    input  logic       bus_write_req,
    input  logic       bus_read_req,
    output word_t      bus_read_data,
    output logic       bus_read_data_valid
);

    localparam int                    c_TAG_BITS    = BUS_ADDR_BITS - ADDR_BITS;
    localparam logic [c_TAG_BITS-1:0] c_BASE        = c_TAG_BITS'(BASE_ADDR);
    localparam ram_state_t            c_RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_BITS:0]    c_FILL_ONE    = {{ADDR_BITS{1'b0}}, 1'b1};

    ram_state_t             r_state, w_state_next;
    logic [ADDR_BITS:0]     r_fill, w_fill_next;
    logic                   w_fill_we;
    logic                   r_ready;

    logic                   w_in_range, w_acc_wr, w_acc_rd;
    byte_en_t               w_arr_we;
    logic [ADDR_BITS-1:0]   w_arr_waddr;
    word_t                  w_arr_wdata, w_arr_q, w_d0;

    logic [READ_LATENCY-1:0] r_vld;
    logic                    r_inr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_RESET_STATE;
            r_fill  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_fill  <= w_fill_next;
            r_ready <= (w_state_next == ST_RUN);
        end
    end

    // The fill counter's MSB rising marks the last word written.
    always_comb begin
        w_state_next = r_state;
        w_fill_next  = r_fill;
        w_fill_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_fill_we   = 1'b1;
                w_fill_next = r_fill + c_FILL_ONE;
                if (w_fill_next[ADDR_BITS]) begin
                    w_state_next = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    assign bus_ready = r_ready;

    // A write wins over a simultaneous read; the read is silently dropped.
    assign w_in_range = (bus_addr[BUS_ADDR_BITS-1:ADDR_BITS] == c_BASE);
    assign w_acc_wr   = bus_ready & bus_write_req;
    assign w_acc_rd   = bus_ready & bus_read_req & ~bus_write_req;

    assign w_arr_we    = w_fill_we ? '1 : ((w_acc_wr & w_in_range) ? bus_byte_enable : '0);
    assign w_arr_waddr = w_fill_we ? r_fill[ADDR_BITS-1:0] : bus_addr[ADDR_BITS-1:0];
    assign w_arr_wdata = w_fill_we ? '0 : bus_write_data;

    system_bus_ram_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_arr_we),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_re    (w_acc_rd),
        .i_raddr (bus_addr[ADDR_BITS-1:0]),
        .o_rdata (w_arr_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            r_inr <= 1'b0;
        end else begin
            r_vld[0] <= w_acc_rd;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            if (w_acc_rd) begin
                r_inr <= w_in_range;
            end
        end
    end

    assign w_d0                = r_inr ? w_arr_q : '0;
    assign bus_read_data_valid = r_vld[READ_LATENCY-1];

    // Data stages load only behind a valid bit, so the output holds between pulses.
    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign bus_read_data = w_d0;
        end else begin : g_latn
            word_t r_dp [1:READ_LATENCY-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 1; k < READ_LATENCY; k++) begin
                        r_dp[k] <= '0;
                    end
                end else begin
                    if (r_vld[0]) begin
                        r_dp[1] <= w_d0;
                    end
                    for (int k = 2; k < READ_LATENCY; k++) begin
                        if (r_vld[k-1]) begin
                            r_dp[k] <= r_dp[k-1];
                        end
                    end
                end
            end

            assign bus_read_data = r_dp[READ_LATENCY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_system_bus_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_system_bus_ram
// Description : Directed self-checking bench for system_bus_ram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_system_bus_ram;

    localparam int L0 = 3;

    logic        clk;
    logic        rst0, rst1;

    logic        rdy0, rvld0, wr0, rd0;
    logic [29:0] addr0;
    logic [31:0] wdata0, rdata0;
    logic [3:0]  be0;

    logic        rdy1, rvld1, wr1, rd1;
    logic [29:0] addr1;
    logic [31:0] wdata1, rdata1;
    logic [3:0]  be1;

    int errors = 0;
    int checks = 0;

    system_bus_ram #(
        .ADDR_BITS(4), .BASE_ADDR(1), .READ_LATENCY(L0), .CLEAR_ON_RESET(1'b1)
    ) u_dut0 (
        .clk(clk), .reset(rst0), .bus_ready(rdy0), .bus_addr(addr0),
        .bus_write_data(wdata0), .bus_byte_enable(be0), .bus_write_req(wr0),
        .bus_read_req(rd0), .bus_read_data(rdata0), .bus_read_data_valid(rvld0)
    );

    system_bus_ram #(
        .ADDR_BITS(4), .BASE_ADDR(0), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b0)
    ) u_dut1 (
        .clk(clk), .reset(rst1), .bus_ready(rdy1), .bus_addr(addr1),
        .bus_write_data(wdata1), .bus_byte_enable(be1), .bus_write_req(wr1),
        .bus_read_req(rd1), .bus_read_data(rdata1), .bus_read_data_valid(rvld1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wr0_word(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        addr0 = a; wdata0 = d; be0 = be; wr0 = 1'b1;
        @(posedge clk); #1;
        wr0 = 1'b0; be0 = 4'h0;
    endtask

    task automatic test_reset();
        int n;
        rst0 = 1'b1; rst1 = 1'b1;
        wr0 = 0; rd0 = 0; be0 = 0; addr0 = '0; wdata0 = '0;
        wr1 = 0; rd1 = 0; be1 = 0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", rdy0); end
        checks++; if (rvld0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", rvld0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", rdata0); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b want=0", rdy1); end
        rst0 = 1'b0;
        n = 0;
        while (rdy0 !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL fill_ready_cycles got=%0d want=16", n); end
    endtask

    task automatic test_fill();
        int i; logic exp_v;
        for (int s = 0; s <= 16 + L0; s++) begin
            if (s < 16) begin rd0 = 1'b1; addr0 = 30'(16 + s); end else rd0 = 1'b0;
            @(posedge clk); #1;
            i = s + 1 - L0;
            exp_v = (i >= 0 && i < 16);
            checks++;
            if (rvld0 !== exp_v) begin errors++; $display("FAIL fill_valid s=%0d got=%b want=%b", s, rvld0, exp_v); end
            if (exp_v) begin
                checks++;
                if (rdata0 !== 32'h0) begin errors++; $display("FAIL fill_data word=%0d got=%h want=0", i, rdata0); end
            end
        end
    endtask

    task automatic test_byte_lanes();
        wr0_word(30'h13, 32'h11223344, 4'hF);
        wr0_word(30'h13, 32'hAABBCCDD, 4'b0101);
        rd0 = 1'b1; addr0 = 30'h13;
        for (int s = 1; s <= L0 + 1; s++) begin
            @(posedge clk); #1; rd0 = 1'b0;
            checks++;
            if (rvld0 !== (s == L0)) begin errors++; $display("FAIL lanes_valid s=%0d got=%b want=%b", s, rvld0, (s == L0)); end
            if (s == L0) begin
                checks++;
                if (rdata0 !== 32'h11BB33DD) begin errors++; $display("FAIL lanes_data got=%h want=11bb33dd", rdata0); end
            end
        end
    endtask

    task automatic test_streaming();
        int i; logic exp_v;
        for (int k = 0; k < 8; k++) wr0_word(30'(16 + k + 4), 32'hA5A50000 | k, 4'hF);
        for (int s = 0; s <= 8 + L0; s++) begin
            if (s < 8) begin rd0 = 1'b1; addr0 = 30'(16 + s + 4); end else rd0 = 1'b0;
            @(posedge clk); #1;
            i = s + 1 - L0;
            exp_v = (i >= 0 && i < 8);
            checks++;
            if (rvld0 !== exp_v) begin errors++; $display("FAIL stream_valid s=%0d got=%b want=%b", s, rvld0, exp_v); end
            if (exp_v) begin
                checks++;
                if (rdata0 !== (32'hA5A50000 | i)) begin
                    errors++; $display("FAIL stream_data idx=%0d got=%h want=%h", i, rdata0, 32'hA5A50000 | i);
                end
            end
        end
    endtask

    task automatic test_raw();
        wr0_word(30'h15, 32'hCAFEF00D, 4'hF);
        rd0 = 1'b1; addr0 = 30'h15;
        for (int s = 1; s <= L0; s++) begin
            @(posedge clk); #1; rd0 = 1'b0;
        end
        checks++; if (rvld0 !== 1'b1) begin errors++; $display("FAIL raw_valid got=%b want=1", rvld0); end
        checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL raw_data got=%h want=cafef00d", rdata0); end
        @(posedge clk); #1;
        checks++; if (rvld0 !== 1'b0) begin errors++; $display("FAIL raw_pulse_width got=%b want=0", rvld0); end
        checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL raw_data_hold got=%h want=cafef00d", rdata0); end
    endtask

    task automatic test_decode();
        logic [29:0] ra   [3] = '{30'h3, 30'h13, 30'h15};
        logic [31:0] rexp [3] = '{32'h0, 32'h11BB33DD, 32'hCAFEF00D};
        int i; logic exp_v;
        wr0_word(30'h3, 32'hDEADBEEF, 4'hF);
        wr0_word(30'h15, 32'hFFFFFFFF, 4'h0);
        for (int s = 0; s <= 3 + L0; s++) begin
            if (s < 3) begin rd0 = 1'b1; addr0 = ra[s]; end else rd0 = 1'b0;
            @(posedge clk); #1;
            i = s + 1 - L0;
            exp_v = (i >= 0 && i < 3);
            checks++;
            if (rvld0 !== exp_v) begin errors++; $display("FAIL decode_valid s=%0d got=%b want=%b", s, rvld0, exp_v); end
            if (exp_v) begin
                checks++;
                if (rdata0 !== rexp[i]) begin errors++; $display("FAIL decode_data idx=%0d got=%h want=%h", i, rdata0, rexp[i]); end
            end
        end
    endtask

    task automatic test_collision();
        addr0 = 30'h16; wdata0 = 32'h12345678; be0 = 4'hF; wr0 = 1'b1; rd0 = 1'b1;
        @(posedge clk); #1;
        wr0 = 1'b0; rd0 = 1'b0; be0 = 4'h0;
        for (int s = 0; s < L0 + 3; s++) begin
            checks++;
            if (rvld0 !== 1'b0) begin errors++; $display("FAIL collision_no_valid s=%0d got=%b want=0", s, rvld0); end
            @(posedge clk); #1;
        end
        rd0 = 1'b1; addr0 = 30'h16;
        for (int s = 1; s <= L0; s++) begin
            @(posedge clk); #1; rd0 = 1'b0;
        end
        checks++; if (rvld0 !== 1'b1) begin errors++; $display("FAIL collision_rd_valid got=%b want=1", rvld0); end
        checks++; if (rdata0 !== 32'h12345678) begin errors++; $display("FAIL collision_write got=%h want=12345678", rdata0); end
    endtask

    task automatic test_reset_inflight();
        int n;
        rd0 = 1'b1; addr0 = 30'h15;
        @(posedge clk); #1; addr0 = 30'h13;
        @(posedge clk); #1; addr0 = 30'h16;
        @(posedge clk); #1; rd0 = 1'b0;
        checks++; if (rvld0 !== 1'b1) begin errors++; $display("FAIL inflight_first_valid got=%b want=1", rvld0); end
        checks++; if (rdata0 !== 32'hCAFEF00D) begin errors++; $display("FAIL inflight_first_data got=%h want=cafef00d", rdata0); end
        #2 rst0 = 1'b1;
        #1;
        checks++; if (rvld0 !== 1'b0) begin errors++; $display("FAIL inflight_valid_drop got=%b want=0", rvld0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL inflight_ready_drop got=%b want=0", rdy0); end
        repeat (2) @(posedge clk);
        #1 rst0 = 1'b0;
        n = 0;
        while (rdy0 !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
            checks++;
            if (rvld0 !== 1'b0) begin errors++; $display("FAIL stale_valid_fill n=%0d got=%b want=0", n, rvld0); end
        end
        checks++; if (n != 16) begin errors++; $display("FAIL refill_ready_cycles got=%0d want=16", n); end
        for (int s = 0; s < 4; s++) begin
            @(posedge clk); #1;
            checks++;
            if (rvld0 !== 1'b0) begin errors++; $display("FAIL stale_valid_run s=%0d got=%b want=0", s, rvld0); end
        end
        rd0 = 1'b1; addr0 = 30'h15;
        for (int s = 1; s <= L0; s++) begin
            @(posedge clk); #1; rd0 = 1'b0;
        end
        checks++; if (rvld0 !== 1'b1) begin errors++; $display("FAIL refill_rd_valid got=%b want=1", rvld0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL refill_zero got=%h want=0", rdata0); end
    endtask

    task automatic test_no_clear_lat1();
        rst1 = 1'b0;
        #1;
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL noclr_ready_early got=%b want=0", rdy1); end
        @(posedge clk); #1;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL noclr_ready got=%b want=1", rdy1); end
        addr1 = 30'h7; wdata1 = 32'h0BADC0DE; be1 = 4'hF; wr1 = 1'b1;
        @(posedge clk); #1;
        wr1 = 1'b0; be1 = 4'h0; rd1 = 1'b1;
        @(posedge clk); #1;
        rd1 = 1'b0;
        checks++; if (rvld1 !== 1'b1) begin errors++; $display("FAIL lat1_valid got=%b want=1", rvld1); end
        checks++; if (rdata1 !== 32'h0BADC0DE) begin errors++; $display("FAIL lat1_data got=%h want=0badc0de", rdata1); end
        @(posedge clk); #1;
        checks++; if (rvld1 !== 1'b0) begin errors++; $display("FAIL lat1_pulse_width got=%b want=0", rvld1); end
        checks++; if (rdata1 !== 32'h0BADC0DE) begin errors++; $display("FAIL lat1_hold got=%h want=0badc0de", rdata1); end
    endtask

    initial begin
        test_reset();
        test_no_clear_lat1();
        test_fill();
        test_byte_lanes();
        test_streaming();
        test_raw();
        test_decode();
        test_collision();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
